// File: rtl/main_ctrl_if.sv
// Bus between the multicycle main controller and the datapath: opcode/flags/ack in,
// every enable, mux select, ALU op and status out.
interface main_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic                 zero;
  logic                 mem_ack;
  logic                 mem_read;
  logic                 mem_write;
  logic                 iord;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [3:0]           state;

  modport master (
    output opcode, zero, mem_ack,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal, instr_count, state
  );

  modport slave (
    input  opcode, zero, mem_ack,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal, instr_count, state
  );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS-subset main control: Moore FSM over fetch/decode/execute/memory/writeback
// with a req/ack memory handshake, retired-instruction counter and illegal-opcode trap.
module main_ctrl_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  main_ctrl_if.slave bus
);

  localparam logic [1:0] ALUOP_LW    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_retire;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = bus.mem_ack ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = bus.mem_ack ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Reset forces the idle decode combinationally so no request leaks out while rst is high.
  always_comb begin
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = ALUOP_LW;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = 2'b01;
          w_ir_write  = bus.mem_ack;
          w_pc_write  = bus.mem_ack;
        end
        S_DECODE: w_alu_src_b = 2'b11;
        S_MEMADR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          w_mem_read = 1'b1;
          w_iord     = 1'b1;
        end
        S_MEMWB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          w_mem_write = 1'b1;
          w_iord      = 1'b1;
        end
        S_EXEC: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = ALUOP_RTYPE;
        end
        S_ALUWB: begin
          w_reg_write = 1'b1;
          w_reg_dst   = 1'b1;
          w_alu_op    = ALUOP_RTYPE;
        end
        S_BRANCH: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = ALUOP_BEQ;
          w_pc_src    = 2'b01;
          w_pc_write  = bus.zero;
        end
        S_JUMP: begin
          w_pc_src   = 2'b10;
          w_pc_write = 1'b1;
        end
        S_TRAP:  w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // An instruction retires on the edge leaving its final state; a store only once acked.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                    ((r_state == S_MEMWR) && bus.mem_ack);

  always_ff @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.iord        = w_iord;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.reg_write   = w_reg_write;
  assign bus.illegal     = w_illegal;
  assign bus.instr_count = r_cnt;
  assign bus.state       = r_state;

endmodule

// File: doc/main_ctrl_fsm.md
# main_ctrl_fsm

Multicycle main control unit for the MIPS-subset datapath, directly upstream of the ALU control decoder. It decodes the 6-bit opcode over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps and drives `alu_op[1:0]` into the ALU control, along with every datapath enable and mux select. Memory accesses use a req/ack handshake, so a slow memory stalls the machine. It also counts retired instructions and traps on illegal opcodes.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26], valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ack`  in  1  memory completes the current read/write in this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  IR load enable.
- `pc_write`  out  1  PC load enable; includes the branch qualification.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op`  out  2  `ALUOP_*` code driven to the ALU control.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `illegal`  out  1  sticky illegal-opcode flag.
- `instr_count`  out  CNT_WIDTH  retired-instruction count.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes: R-type = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010. Any other opcode is illegal.
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, TRAP = 10. Encodings 11–15 go to FETCH on the next edge.
- Outputs are a Moore decode of `state`. The only exceptions are the `mem_ack`/`zero` gating listed below. Any output not listed for a state is 0; `alu_op` defaults to `ALUOP_LW`.

Per-state outputs and transitions:
- **FETCH**: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=`ALUOP_LW`, `pc_src`=00.
  - `ir_write` = `pc_write` = `mem_ack`.
  - Stays in FETCH until `mem_ack`, then goes to DECODE.
- **DECODE**: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=`ALUOP_LW` (computes the branch target into ALUOut).
  - Next state: LW/SW → MEMADR, R-type → EXEC, BEQ → BRANCH, J → JUMP, otherwise → TRAP.
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=`ALUOP_LW`.
  - Next state: MEMRD for LW, MEMWR for SW. The opcode is re-decoded here.
- **MEMRD**: `mem_read`=1, `iord`=1. Holds until `mem_ack`, then goes to MEMWB.
- **MEMWB**: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- **MEMWR**: `mem_write`=1, `iord`=1. Holds until `mem_ack`, then goes to FETCH.
- **EXEC**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=`ALUOP_RTYPE`. Goes to ALUWB.
- **ALUWB**: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=1, `alu_op`=`ALUOP_RTYPE`. Goes to FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=`ALUOP_BEQ`, `pc_src`=01, `pc_write`=`zero`. Goes to FETCH.
- **JUMP**: `pc_src`=10, `pc_write`=1. Goes to FETCH.
- **TRAP**: `illegal`=1, all enables 0. Stays in TRAP until `rst`.

Memory handshake:
- `mem_read`/`mem_write` stay asserted and stable every cycle until `mem_ack` is sampled high.
- `mem_ack` is ignored outside FETCH, MEMRD and MEMWR.
- A read and a write are never requested in the same cycle.

Retired-instruction counter:
- `instr_count` increments by 1 on the edge that leaves MEMWB, ALUWB, BRANCH or JUMP, and on the edge that leaves MEMWR with `mem_ack` high.
- It wraps modulo 2^CNT_WIDTH.
- It never increments in TRAP.

## Timing
- Reset:
  - While `rst` is high, all 1-bit outputs and `pc_src`, `alu_src_b` are 0, and `alu_op` = `ALUOP_LW`.
  - On the edge where `rst` is sampled high: `state` = FETCH, `instr_count` = 0, `illegal` = 0.
  - The first request after reset is in the first cycle with `rst` low: `mem_read` = 1.
- Reset mid-operation (including a wait on ack) aborts the instruction. Its count is not incremented.
- Latency with zero-wait memory (`mem_ack` high in the first request cycle):
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - J: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- `pc_write` and `ir_write` pulse for exactly one cycle per fetch, regardless of wait states.

## Test plan
- Reset, then an R-type instruction with `mem_ack` tied high → states 0→1→6→7→0. `alu_op`=`ALUOP_RTYPE` in EXEC. `reg_write`=1 and `reg_dst`=1 only in cycle 4. `instr_count`=1.
- LW with `mem_ack` delayed 3 cycles in both FETCH and MEMRD → `mem_read` held 4 cycles each time. `ir_write` is a single pulse. Total 11 cycles. `mem_to_reg`=1 in MEMWB. `instr_count`=1.
- BEQ with `zero`=1, then BEQ with `zero`=0 → `pc_write`=1 with `pc_src`=01 in the first BRANCH; `pc_write`=0 in the second. `alu_op`=`ALUOP_BEQ` in both. `instr_count`=2.
- SW then J → `mem_write`=1 with `iord`=1 in MEMWR. `pc_write`=1 with `pc_src`=10 in JUMP. `instr_count`=2.
- Opcode 111111 → TRAP. `illegal`=1 and stays 1 for 20 cycles. All enables 0. `instr_count` unchanged. Asserting `rst` clears it to FETCH with `illegal`=0.
- `rst` asserted during the MEMRD wait → next state FETCH, `mem_read` deasserts during reset, `instr_count`=0. Also preload `instr_count` to all ones and retire one instruction → count wraps to 0.
